// File: rtl/mul_seq_ctrl.sv
// ----------------------------------------------------------------------------
// MulSeqCtrl -- controller for a repeated-addition multiplier.
//
// The controller drives a datapath made of three parts:
//   * an operand register A,
//   * a loadable 16-bit down-counter B,
//   * a product accumulator P that adds A on each step.
// A multiply runs as follows. The controller loads A, then loads B and clears
// P in the same cycle. It then issues one add-and-decrement per cycle until the
// counter reports zero. It ends with a one-cycle done pulse. The block carries
// no data of its own; it only sequences the datapath enables.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   start_i      request a multiply (only looked at while idle)
//   abort_i      synchronous abort back to idle (ignored while idle)
//   eqz_i        datapath flag: B counter currently equals zero
//   ld_a_o       load operand register A
//   ld_b_o       load the B counter
//   clr_p_o      clear accumulator P
//   ld_p_o       accumulate P <= P + A
//   dec_b_o      decrement the B counter
//   busy_o       high whenever the controller is not idle
//   done_o       one-cycle completion pulse
//   iter_cnt_o   number of add cycles issued in the current/last operation
// ----------------------------------------------------------------------------
module mul_seq_ctrl #(
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          eqz_i,
    output logic          ld_a_o,
    output logic          ld_b_o,
    output logic          clr_p_o,
    output logic          ld_p_o,
    output logic          dec_b_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] iter_cnt_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        ADD    = 3'd3,
        DONE   = 3'd4
    } state_e;

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] iterCnt_q;
    logic [CW-1:0] iterCnt_d;

    // State and iteration counter registers. Reset drops any operation in
    // flight immediately. No done pulse follows, because DONE can only be
    // reached through ADD.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            iterCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            iterCnt_q <= iterCnt_d;
        end
    end

    // Next-state and output decode. Outputs are Moore, taken from the current
    // state. The exception is ADD, where the add/decrement enables are
    // suppressed once the counter reads zero. That final ADD cycle only
    // detects completion and issues no add.
    // Abort is applied last, so it overrides every transition, including
    // DONE -> IDLE. The iteration count still takes an add issued in the same
    // cycle as the abort, because the datapath performs that add regardless.
    always_comb begin
        state_d   = state_q;
        iterCnt_d = iterCnt_q;
        ld_a_o    = 1'b0;
        ld_b_o    = 1'b0;
        clr_p_o   = 1'b0;
        ld_p_o    = 1'b0;
        dec_b_o   = 1'b0;
        done_o    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    state_d   = LOAD_A;
                    iterCnt_d = '0;
                end
            end
            LOAD_A: begin
                ld_a_o  = 1'b1;
                state_d = LOAD_B;
            end
            LOAD_B: begin
                ld_b_o  = 1'b1;
                clr_p_o = 1'b1;
                state_d = ADD;
            end
            ADD: begin
                if (!eqz_i) begin
                    ld_p_o    = 1'b1;
                    dec_b_o   = 1'b1;
                    iterCnt_d = iterCnt_q + CW'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    // Busy covers every state other than IDLE, including illegal codes,
    // until those codes recover to IDLE.
    always_comb begin
        busy_o     = (state_q != IDLE);
        iter_cnt_o = iterCnt_q;
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mul_seq_ctrl -- self-checking bench for mul_seq_ctrl.
//
// The bench surrounds the controller with a behavioural datapath: an A
// register, a B down-counter that drives eqz, and a P accumulator. A
// reference model tracks each operation as an index k, counted in cycles
// since the start was accepted. With multiplier N, the expected schedule is:
//   k = 1            load A
//   k = 2            load B and clear P
//   k = 3 .. N+2     add and decrement
//   k = N+3          final ADD with nothing issued
//   k = N+4          done
// All outputs are compared against that schedule on every negative edge.
// Directed scenarios add literal checks on top of this: done timing, product
// values, and iteration counts.
// ----------------------------------------------------------------------------
module tb_mul_seq_ctrl;

    localparam int CW = 16;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          eqz;
    logic          ldA, ldB, clrP, ldP, decB, busy, done;
    logic [CW-1:0] iterCnt;

    logic [15:0]   opA = 16'd0;
    logic [15:0]   opB = 16'd0;
    logic [15:0]   regA;
    logic [15:0]   regB;
    logic [31:0]   regP;

    int            cyc = 0;
    int            total = 0;
    int            bad = 0;
    int            doneTotal = 0;
    int            ldpTotal = 0;
    int            lastDoneCyc = 0;

    bit            refActive = 1'b0;
    int            refK = 0;
    int            refN = 0;
    logic [CW-1:0] refIter = '0;

    // Free-running clock and a cycle index. The index is used to time the
    // done pulse relative to the cycle in which start was presented.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mul_seq_ctrl #(.CW(CW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .abort_i    (abort),
        .eqz_i      (eqz),
        .ld_a_o     (ldA),
        .ld_b_o     (ldB),
        .clr_p_o    (clrP),
        .ld_p_o     (ldP),
        .dec_b_o    (decB),
        .busy_o     (busy),
        .done_o     (done),
        .iter_cnt_o (iterCnt)
    );

    // Behavioural datapath driven by the controller's enables. The operands
    // come from opA/opB, which stand in for the shared data input.
    assign eqz = (regB == 16'd0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            regA <= 16'd0;
            regB <= 16'd0;
            regP <= 32'd0;
        end else begin
            if (ldA) regA <= opA;
            if (ldB) regB <= opB;
            else if (decB) regB <= regB - 16'd1;
            if (clrP) regP <= 32'd0;
            else if (ldP) regP <= regP + {16'd0, regA};
        end
    end

    // Reference model. It tracks whether an operation is in flight and how
    // many cycles have passed since acceptance. It also counts the add
    // cycles issued.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            refActive <= 1'b0;
            refK      <= 0;
            refN      <= 0;
            refIter   <= '0;
        end else if (!refActive) begin
            if (start && !abort) begin
                refActive <= 1'b1;
                refK      <= 1;
                refN      <= int'(opB);
                refIter   <= '0;
            end
        end else begin
            if (refK >= 3 && refK <= refN + 2) refIter <= refIter + 16'd1;
            if (abort || refK == refN + 4) refActive <= 1'b0;
            else refK <= refK + 1;
        end
    end

    // Single comparison point. Every check, whether per-cycle or literal,
    // goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare of every DUT output against the model's schedule.
    // It also keeps running tallies of done and ld_p pulses for the
    // scenario checks.
    task automatic checkCycle();
        bit act;
        bit eA, eB, eAdd, eDone;
        act   = refActive && !rst;
        eA    = act && (refK == 1);
        eB    = act && (refK == 2);
        eAdd  = act && (refK >= 3) && (refK <= refN + 2);
        eDone = act && (refK == refN + 4);
        checkOutput("ld_a",  32'(ldA),  32'(eA));
        checkOutput("ld_b",  32'(ldB),  32'(eB));
        checkOutput("clr_p", 32'(clrP), 32'(eB));
        checkOutput("ld_p",  32'(ldP),  32'(eAdd));
        checkOutput("dec_b", 32'(decB), 32'(eAdd));
        checkOutput("busy",  32'(busy), 32'(act));
        checkOutput("done",  32'(done), 32'(eDone));
        checkOutput("iter",  32'(iterCnt), rst ? 32'd0 : 32'(refIter));
        if (done === 1'b1) begin
            doneTotal++;
            lastDoneCyc = cyc;
        end
        if (ldP === 1'b1) ldpTotal++;
    endtask

    // Advance one cycle. Outputs are sampled on the falling edge, and inputs
    // change shortly after it.
    task automatic nextCycle();
        @(negedge clk);
        checkCycle();
        #1;
    endtask

    task automatic waitDone(input int base, input int limit, input string tag);
        int n = 0;
        while (doneTotal == base && n < limit) begin
            nextCycle();
            n++;
        end
        checkOutput({tag, "_doneSeen"}, 32'(doneTotal - base), 32'd1);
    endtask

    // Run one complete multiply. Returns the cycle in which start was high.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input string tag, output int tS);
        int base;
        opA   = a;
        opB   = b;
        base  = doneTotal;
        start = 1'b1;
        tS    = cyc;
        nextCycle();
        start = 1'b0;
        waitDone(base, int'(b) + 10, tag);
    endtask

    initial begin
        int tS;
        int base;
        int ldpBase;
        int n;
        int abortAt;
        bit aborted;
        logic [15:0] a;
        logic [15:0] b;

        // Reset state.
        repeat (3) nextCycle();
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetIter", 32'(iterCnt), 32'd0);
        rst = 1'b0;
        repeat (2) nextCycle();

        // Normal multiply 7 x 3.
        ldpBase = ldpTotal;
        applyStimulus(16'd7, 16'd3, "mul7x3", tS);
        checkOutput("mul7x3_doneCyc", 32'(lastDoneCyc - tS), 32'd7);
        checkOutput("mul7x3_P", regP, 32'd21);
        checkOutput("mul7x3_iter", 32'(iterCnt), 32'd3);
        checkOutput("mul7x3_adds", 32'(ldpTotal - ldpBase), 32'd3);
        nextCycle();

        // Zero multiplier.
        ldpBase = ldpTotal;
        applyStimulus(16'd9, 16'd0, "mul9x0", tS);
        checkOutput("mul9x0_doneCyc", 32'(lastDoneCyc - tS), 32'd4);
        checkOutput("mul9x0_P", regP, 32'd0);
        checkOutput("mul9x0_iter", 32'(iterCnt), 32'd0);
        checkOutput("mul9x0_adds", 32'(ldpTotal - ldpBase), 32'd0);
        nextCycle();

        // Abort during the fourth add cycle of 4 x 10.
        opA = 16'd4;
        opB = 16'd10;
        base = doneTotal;
        ldpBase = ldpTotal;
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        n = 0;
        while ((ldpTotal - ldpBase) < 4 && n < 30) begin
            nextCycle();
            n++;
        end
        abort = 1'b1;
        nextCycle();
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_iter", 32'(iterCnt), 32'd4);
        checkOutput("abort_P", regP, 32'd16);
        repeat (6) nextCycle();
        checkOutput("abort_noDone", 32'(doneTotal - base), 32'd0);
        checkOutput("abort_iterHold", 32'(iterCnt), 32'd4);
        applyStimulus(16'd4, 16'd2, "mul4x2", tS);
        checkOutput("mul4x2_P", regP, 32'd8);
        checkOutput("mul4x2_iter", 32'(iterCnt), 32'd2);
        nextCycle();

        // Start pulsed while busy, then start held through DONE for a
        // back-to-back second operation.
        opA = 16'd2;
        opB = 16'd4;
        base = doneTotal;
        ldpBase = ldpTotal;
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        n = 0;
        while ((ldpTotal - ldpBase) < 1 && n < 10) begin
            nextCycle();
            n++;
        end
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        opA = 16'd3;
        opB = 16'd5;
        start = 1'b1;
        waitDone(base, 20, "b2bFirst");
        checkOutput("b2bFirst_P", regP, 32'd8);
        nextCycle();
        checkOutput("b2bIdle_busy", 32'(busy), 32'd0);
        checkOutput("b2bIdle_ldA", 32'(ldA), 32'd0);
        nextCycle();
        checkOutput("b2bLoadA", 32'(ldA), 32'd1);
        start = 1'b0;
        base = doneTotal;
        waitDone(base, 20, "b2bSecond");
        checkOutput("b2bSecond_P", regP, 32'd15);
        checkOutput("b2bSecond_iter", 32'(iterCnt), 32'd5);
        nextCycle();

        // Randomised operations with stray starts and occasional aborts.
        for (int op = 0; op < 16; op++) begin
            a = 16'($urandom_range(0, 255));
            b = 16'($urandom_range(0, 24));
            abortAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(b) + 4)) : -1;
            aborted = 1'b0;
            opA = a;
            opB = b;
            base = doneTotal;
            start = 1'b1;
            tS = cyc;
            nextCycle();
            start = 1'b0;
            for (int j = 1; j <= int'(b) + 4; j++) begin
                abort = (j == abortAt);
                start = ($urandom_range(0, 5) == 0);
                nextCycle();
                if (abort) begin
                    aborted = 1'b1;
                    break;
                end
            end
            start = 1'b0;
            abort = 1'b0;
            if (!aborted) begin
                checkOutput($sformatf("rnd%0d_done", op), 32'(doneTotal - base), 32'd1);
                checkOutput($sformatf("rnd%0d_doneCyc", op), 32'(lastDoneCyc - tS), 32'(int'(b) + 4));
                checkOutput($sformatf("rnd%0d_P", op), regP, 32'(a) * 32'(b));
                checkOutput($sformatf("rnd%0d_iter", op), 32'(iterCnt), 32'(b));
            end
            repeat (2) nextCycle();
        end

        // Asynchronous reset in the middle of an ADD cycle.
        opA = 16'd6;
        opB = 16'd5;
        ldpBase = ldpTotal;
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        n = 0;
        while ((ldpTotal - ldpBase) < 2 && n < 20) begin
            nextCycle();
            n++;
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rstMid_ldP", 32'(ldP), 32'd0);
        checkOutput("rstMid_decB", 32'(decB), 32'd0);
        checkOutput("rstMid_busy", 32'(busy), 32'd0);
        checkOutput("rstMid_done", 32'(done), 32'd0);
        checkOutput("rstMid_iter", 32'(iterCnt), 32'd0);
        repeat (2) nextCycle();
        rst = 1'b0;
        base = doneTotal;
        repeat (10) nextCycle();
        checkOutput("rstMid_noDone", 32'(doneTotal - base), 32'd0);

        // Full-range multiplier: no wrap of the iteration count.
        applyStimulus(16'd1, 16'hFFFF, "mulMax", tS);
        checkOutput("mulMax_doneCyc", 32'(lastDoneCyc - tS), 32'd65539);
        checkOutput("mulMax_iter", 32'(iterCnt), 32'h0000FFFF);
        checkOutput("mulMax_P", regP, 32'd65535);
        nextCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Controller FSM that sequences the repeated-addition multiplier datapath: operand register A, loadable down-counter B (ld/dec, 16-bit), and product accumulator P (P <= P + A).
- Takes a start request, loads A, then B, then clears P, and issues one add-and-decrement per cycle until the counter's zero flag asserts.
- Reports completion with a one-cycle done pulse and an iteration count.
- Sits between the top-level testbench/host and the datapath; purely control, no data bus.

Parameters:
- CW, 16, width of the iteration counter output; matches the datapath counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a multiply; sampled only in IDLE.
- abort  input  1  synchronous abort; returns FSM to IDLE.
- eqz  input  1  datapath flag, 1 when the B counter output equals 0 (combinational from the counter register).
- ld_a  output  1  load operand register A from the shared data input.
- ld_b  output  1  load B counter (drives counter ld).
- clr_p  output  1  clear accumulator P to 0.
- ld_p  output  1  accumulate P <= P + A.
- dec_b  output  1  decrement B counter (drives counter dec).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- iter_cnt  output  CW  number of add cycles issued in the current/last operation.

Behaviour:
- Reset (async, rst=1): state=IDLE, iter_cnt=0; all control outputs 0, busy=0, done=0. Reset mid-operation discards the operation; no done.
- States, 3-bit encoding: IDLE=0, LOAD_A=1, LOAD_B=2, ADD=3, DONE=4. Codes 5-7 go to IDLE on the next edge.
- Outputs are decoded combinationally from state (Moore), except that ADD outputs are gated by eqz:
  - LOAD_A: ld_a=1.
  - LOAD_B: ld_b=1, clr_p=1.
  - ADD: ld_p = dec_b = ~eqz.
  - DONE: done=1.
  - All other control outputs are 0 in each state.
- Transitions:
  - IDLE -> LOAD_A when start=1; otherwise stay. On acceptance, iter_cnt <= 0.
  - LOAD_A -> LOAD_B unconditionally.
  - LOAD_B -> ADD unconditionally. The counter is loaded on this edge, so eqz is valid in the first ADD cycle.
  - ADD -> ADD while eqz=0; each such cycle performs one add and one decrement, and iter_cnt increments.
  - ADD -> DONE when eqz=1, with no add issued that cycle.
  - DONE -> IDLE unconditionally.
- Timing: start sampled high at edge T gives LOAD_A at cycle T+1, LOAD_B at T+2, ADD from T+3. For B=N, there are N add cycles, one final ADD cycle with eqz=1, and done at cycle T+4+N.
- B=0: a single ADD cycle with eqz=1, no ld_p. done at T+4, P=0, iter_cnt=0.
- iter_cnt holds its value after done until the next start is accepted. It wraps modulo 2^CW; unreachable with CW >= counter width.
- abort=1 in any non-IDLE state: next state is IDLE, no done, iter_cnt holds its value.
  - abort has priority over all transitions, including DONE -> IDLE. done still shows for the DONE cycle because it is Moore.
  - abort in IDLE is ignored. abort and start together in IDLE: stay in IDLE.
- start while busy is ignored. start held high in DONE is not accepted until IDLE is reached, so back-to-back operations have one IDLE cycle between done and LOAD_A.
- eqz is ignored outside ADD.

Test Plan:
- Reset: assert rst asynchronously mid-cycle during ADD with B=5 -> all outputs 0 immediately, state IDLE, no done afterwards, iter_cnt=0.
- Normal multiply: A=7, B=3, start pulse at T -> ld_a at T+1; ld_b and clr_p at T+2; ld_p and dec_b high at T+3..T+5; done at T+7. Datapath P=21, iter_cnt=3.
- Zero multiplier: A=9, B=0 -> no ld_p/dec_b pulses, done at T+4, P=0, iter_cnt=0.
- Abort: A=4, B=10, abort during the 4th add cycle -> IDLE next cycle, no done, busy=0, iter_cnt=4. A following start with B=2 -> done, P=8, iter_cnt=2.
- Start while busy and back-to-back: pulse start during ADD -> ignored. Hold start high through DONE -> exactly one IDLE cycle, then LOAD_A. Second result A=3, B=5 gives P=15.
- Large B: A=1, B=16'hFFFF -> 65535 add cycles, done at T+65539, iter_cnt=16'hFFFF, no wrap.
